// File: rtl/unsign_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Restarts automatically whenever the operand inputs differ from the latched pair.
module unsign_divider #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [INPUT_BIT_WIDTH-1:0] Dividend,
  input  logic [INPUT_BIT_WIDTH-1:0] Divider,
  output logic [INPUT_BIT_WIDTH-1:0] Quotient,
  output logic [INPUT_BIT_WIDTH-1:0] Remainder,
  output logic                       Ready
);

  localparam int W  = INPUT_BIT_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   shq_q, shq_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   remo_q, remo_d;
  logic           ready_q, ready_d;

  logic           start;
  logic [W+1:0]   rem_sh;
  logic [W+1:0]   diff;
  logic           qbit;
  logic [W:0]     rem_next;
  logic [W-1:0]   shq_next;

  always_comb begin
    start    = !valid_q || (Dividend != opa_q) || (Divider != opb_q);
    // Sign bit of the widened difference doubles as the "rem >= divisor" compare.
    rem_sh   = {rem_q, shq_q[W-1]};
    diff     = rem_sh - {2'b00, opb_q};
    qbit     = !diff[W+1];
    rem_next = qbit ? diff[W:0] : rem_sh[W:0];
    shq_next = {shq_q[W-2:0], qbit};

    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    shq_d   = shq_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ready_d = ready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = Dividend;
          opb_d   = Divider;
          rem_d   = '0;
          shq_d   = Dividend;
          cnt_d   = CW'(W);
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = rem_next;
        shq_d = shq_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = shq_next;
          remo_d  = rem_next[W-1:0];
          ready_d = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      shq_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      shq_q   <= shq_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ready_q <= ready_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = remo_q;
  assign Ready     = ready_q;

endmodule

// File: tb/tb_unsign_divider.sv
// Directed and random checks of unsign_divider with a queue of expected results.
module tb_unsign_divider;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] Dividend = 8'd13;
  logic [W-1:0] Divider = 8'd2;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Ready;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] sb[$];

  unsign_divider #(.INPUT_BIT_WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Dividend  (Dividend),
    .Divider   (Divider),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Ready     (Ready)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge Clk);
      #1;
      n++;
      if (Ready) break;
    end
    if (!Ready) check("ready_timeout", 32'(Ready), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [2*W-1:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"}, 32'(Quotient), 32'(e[2*W-1:W]));
      check({tag, "_r"}, 32'(Remainder), 32'(e[W-1:0]));
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n;
    @(negedge Clk);
    Dividend = a;
    Divider  = b;
    sb.push_back(model(a, b));
    @(posedge Clk);
    #1;
    check({tag, "_drop"}, 32'(Ready), 32'd0);
    wait_ready(n);
    check({tag, "_lat"}, 32'(n), 32'd8);
    pop_check(tag);
  endtask

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state
    #12;
    check("rst_q", 32'(Quotient), 32'd0);
    check("rst_r", 32'(Remainder), 32'd0);
    check("rst_rdy", 32'(Ready), 32'd0);

    // 13/2 after reset release, then held while inputs are stable
    @(negedge Clk);
    Reset = 1'b0;
    sb.push_back(model(8'd13, 8'd2));
    @(posedge Clk);
    #1;
    check("t1_drop", 32'(Ready), 32'd0);
    wait_ready(n);
    check("t1_lat", 32'(n), 32'd8);
    pop_check("t1");
    repeat (5) @(posedge Clk);
    #1;
    check("t1_hold_rdy", 32'(Ready), 32'd1);
    check("t1_hold_q", 32'(Quotient), 32'd6);
    check("t1_hold_r", 32'(Remainder), 32'd1);

    // Boundary operand pairs, including divide by zero
    run_div(8'd255, 8'd1, "t2_255_1");
    run_div(8'd7, 8'd9, "t2_7_9");
    run_div(8'd200, 8'd200, "t2_200_200");
    run_div(8'd100, 8'd0, "t3_div0");

    // Operands change during BUSY: ignored until completion, then restart
    @(negedge Clk);
    Dividend = 8'd13;
    Divider  = 8'd2;
    sb.push_back(model(8'd13, 8'd2));
    @(posedge Clk);
    #1;
    check("t4_drop", 32'(Ready), 32'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Dividend = 8'd50;
    Divider  = 8'd7;
    sb.push_back(model(8'd50, 8'd7));
    wait_ready(n);
    check("t4_lat_a", 32'(n + 3), 32'd8);
    pop_check("t4_a");
    @(posedge Clk);
    #1;
    check("t4_pulse", 32'(Ready), 32'd0);
    wait_ready(n);
    check("t4_lat_b", 32'(n), 32'd8);
    pop_check("t4_b");

    // Asynchronous reset in the middle of a division
    @(negedge Clk);
    Dividend = 8'd77;
    Divider  = 8'd5;
    @(posedge Clk);
    repeat (4) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("t5_rst_q", 32'(Quotient), 32'd0);
    check("t5_rst_r", 32'(Remainder), 32'd0);
    check("t5_rst_rdy", 32'(Ready), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    sb.push_back(model(8'd77, 8'd5));
    @(posedge Clk);
    #1;
    check("t5_drop", 32'(Ready), 32'd0);
    wait_ready(n);
    check("t5_lat", 32'(n), 32'd8);
    pop_check("t5");

    // Random sweep; each pair differs from the latched one so a division starts
    for (int i = 0; i < 1000; i++) begin
      do begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end while (a == Dividend && b == Divider);
      run_div(a, b, "rnd");
      if (b != '0) begin
        check("rnd_identity", 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
        check("rnd_rem_lt", 32'(Remainder < b), 32'd1);
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
